// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front pipe: opcodes, functs, ALU ops,
// per-stage control bundles and the ID/EX register layout.
package mips_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_LUI  = 4'd10, ALU_ADDU = 4'd11,
    ALU_SUBU = 4'd12
  } alu_op_t;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    alu_op_t alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t    ex;
    m_ctrl_t     m;
    wb_ctrl_t    wb;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU. Only the trapping ADD/SUB report overflow;
// ADDU/SUBU (also used for addresses and branch compares) never do.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_t     op,
  output logic [31:0] y,
  output logic        zero,
  output logic        over
);

  // Result select and signed-overflow detection
  always_comb begin
    y    = 32'h0;
    over = 1'b0;
    case (op)
      ALU_ADD:  begin
        y    = a + b;
        over = (a[31] == b[31]) && (y[31] != a[31]);
      end
      ALU_SUB:  begin
        y    = a - b;
        over = (a[31] != b[31]) && (y[31] != a[31]);
      end
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'h0, a < b};
      ALU_SLL:  y = b << shamt;
      ALU_SRL:  y = b >> shamt;
      ALU_LUI:  y = {b[15:0], 16'h0};
      ALU_ADDU: y = a + b;
      ALU_SUBU: y = a - b;
      default:  y = 32'h0;
    endcase
  end

  assign zero = (y == 32'h0);

endmodule

// File: rtl/mips_front_pipe.sv
// IF, ID and EX stages of a 5-stage MIPS R2000 pipeline, ending in the
// EX/MEM register. Branches/jumps resolve in ID with one delay slot.
// ROM contents are preloaded externally (image named by IMEM_FILE).
module mips_front_pipe #(
  parameter int          IMEM_DEPTH = 256,
  parameter              IMEM_FILE  = "program.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = mips_pkg::EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        except,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_register,
  input  logic [31:0] wb_write_data,
  output logic [31:0] res,
  output logic [31:0] write_data_ex,
  output logic [4:0]  write_register_ex,
  output logic [2:0]  m_mem,
  output logic [1:0]  wb_mem,
  output logic        zero,
  output logic        over,
  output logic [31:0] pc_if,
  output logic [31:0] inst_id
);
  import mips_pkg::*;

  localparam int AW = $clog2(IMEM_DEPTH);

  // ---------------- IF ----------------
  logic [31:0] pc, pc4_if, inst_if;
  logic [31:0] rom [IMEM_DEPTH];

  assign pc4_if  = pc + 32'd4;
  assign inst_if = rom[pc[AW+1:2]];
  assign pc_if   = pc;

  logic [31:0] ifid_pc4, ifid_inst;
  assign inst_id = ifid_inst;

  // ---------------- ID ----------------
  logic [5:0]  opcode, funct;
  logic [4:0]  rs_id, rt_id, rd_id, shamt_id;
  logic [15:0] imm16;
  assign opcode   = ifid_inst[31:26];
  assign rs_id    = ifid_inst[25:21];
  assign rt_id    = ifid_inst[20:16];
  assign rd_id    = ifid_inst[15:11];
  assign shamt_id = ifid_inst[10:6];
  assign funct    = ifid_inst[5:0];
  assign imm16    = ifid_inst[15:0];

  ex_ctrl_t ex_id;
  m_ctrl_t  m_id;
  wb_ctrl_t wb_id;
  logic     sext_id, is_beq, is_bne, is_j;

  // Main decoder; the all-zero word is a true NOP (no write to r0)
  always_comb begin
    ex_id   = '0;
    m_id    = '0;
    wb_id   = '0;
    sext_id = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (ifid_inst != 32'h0) begin
          ex_id.reg_dst   = 1'b1;
          wb_id.reg_write = 1'b1;
          case (funct)
            F_ADD:   ex_id.alu_op = ALU_ADD;
            F_ADDU:  ex_id.alu_op = ALU_ADDU;
            F_SUB:   ex_id.alu_op = ALU_SUB;
            F_SUBU:  ex_id.alu_op = ALU_SUBU;
            F_AND:   ex_id.alu_op = ALU_AND;
            F_OR:    ex_id.alu_op = ALU_OR;
            F_XOR:   ex_id.alu_op = ALU_XOR;
            F_NOR:   ex_id.alu_op = ALU_NOR;
            F_SLT:   ex_id.alu_op = ALU_SLT;
            F_SLTU:  ex_id.alu_op = ALU_SLTU;
            F_SLL:   ex_id.alu_op = ALU_SLL;
            F_SRL:   ex_id.alu_op = ALU_SRL;
            default: begin
              ex_id = '0;
              wb_id = '0;
            end
          endcase
        end
      end
      OP_ADDI:  begin ex_id.alu_src = 1'b1; ex_id.alu_op = ALU_ADD;  wb_id.reg_write = 1'b1; sext_id = 1'b1; end
      OP_ADDIU: begin ex_id.alu_src = 1'b1; ex_id.alu_op = ALU_ADDU; wb_id.reg_write = 1'b1; sext_id = 1'b1; end
      OP_SLTI:  begin ex_id.alu_src = 1'b1; ex_id.alu_op = ALU_SLT;  wb_id.reg_write = 1'b1; sext_id = 1'b1; end
      OP_ANDI:  begin ex_id.alu_src = 1'b1; ex_id.alu_op = ALU_AND;  wb_id.reg_write = 1'b1; end
      OP_ORI:   begin ex_id.alu_src = 1'b1; ex_id.alu_op = ALU_OR;   wb_id.reg_write = 1'b1; end
      OP_XORI:  begin ex_id.alu_src = 1'b1; ex_id.alu_op = ALU_XOR;  wb_id.reg_write = 1'b1; end
      OP_LUI:   begin ex_id.alu_src = 1'b1; ex_id.alu_op = ALU_LUI;  wb_id.reg_write = 1'b1; end
      OP_LW: begin
        ex_id.alu_src = 1'b1; ex_id.alu_op = ALU_ADDU; sext_id = 1'b1;
        m_id.mem_read = 1'b1; wb_id.reg_write = 1'b1; wb_id.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ex_id.alu_src = 1'b1; ex_id.alu_op = ALU_ADDU; sext_id = 1'b1;
        m_id.mem_write = 1'b1;
      end
      OP_BEQ: begin ex_id.alu_op = ALU_SUBU; m_id.branch = 1'b1; sext_id = 1'b1; is_beq = 1'b1; end
      OP_BNE: begin ex_id.alu_op = ALU_SUBU; m_id.branch = 1'b1; sext_id = 1'b1; is_bne = 1'b1; end
      OP_J:   is_j = 1'b1;
      default: ;
    endcase
  end

  logic [31:0] rf [32];
  logic [31:0] rd1_id, rd2_id, imm_id;

  // Register file write from WB; r0 is never stored
  always_ff @(posedge clk) begin
    if (wb_reg_write && wb_write_register != 5'd0)
      rf[wb_write_register] <= wb_write_data;
  end

  // Reads see a same-cycle WB write
  assign rd1_id = (rs_id == 5'd0) ? 32'h0 :
                  (wb_reg_write && wb_write_register == rs_id) ? wb_write_data : rf[rs_id];
  assign rd2_id = (rt_id == 5'd0) ? 32'h0 :
                  (wb_reg_write && wb_write_register == rt_id) ? wb_write_data : rf[rt_id];
  assign imm_id = sext_id ? {{16{imm16[15]}}, imm16} : {16'h0, imm16};

  // EX/MEM result is a valid forwarding source unless it is still a load
  logic        exmem_fwd;
  logic [31:0] cmp_a, cmp_b, pc_branch;
  logic        br;
  assign exmem_fwd = wb_mem[1] && !m_mem[1] && write_register_ex != 5'd0;
  assign cmp_a     = (exmem_fwd && write_register_ex == rs_id) ? res : rd1_id;
  assign cmp_b     = (exmem_fwd && write_register_ex == rt_id) ? res : rd2_id;
  assign br        = is_j | (is_beq & (cmp_a == cmp_b)) | (is_bne & (cmp_a != cmp_b));
  assign pc_branch = is_j ? {ifid_pc4[31:28], ifid_inst[25:0], 2'b00}
                          : ifid_pc4 + {imm_id[29:0], 2'b00};

  // ---------------- hazards ----------------
  idex_t      idex;
  logic [4:0] idex_dest;
  logic       load_use, br_dep, stall;
  assign idex_dest = idex.ex.reg_dst ? idex.rd : idex.rt;

  function automatic logic src_hit(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return (d != 5'd0) && (d == a || d == b);
  endfunction

  assign load_use = idex.m.mem_read && src_hit(idex_dest, rs_id, rt_id);
  assign br_dep   = (is_beq | is_bne) &&
                    ((idex.wb.reg_write && src_hit(idex_dest, rs_id, rt_id)) ||
                     (m_mem[1] && src_hit(write_register_ex, rs_id, rt_id)));
  assign stall    = load_use | br_dep;

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y;
  logic        alu_zero, alu_over;

  assign fwd_a = (exmem_fwd && write_register_ex == idex.rs) ? res :
                 (wb_reg_write && wb_write_register != 5'd0 && wb_write_register == idex.rs) ? wb_write_data :
                 idex.rd1;
  assign fwd_b = (exmem_fwd && write_register_ex == idex.rt) ? res :
                 (wb_reg_write && wb_write_register != 5'd0 && wb_write_register == idex.rt) ? wb_write_data :
                 idex.rd2;
  assign alu_b = idex.ex.alu_src ? idex.imm : fwd_b;

  mips_alu u_alu (
    .a     (fwd_a),
    .b     (alu_b),
    .shamt (idex.shamt),
    .op    (idex.ex.alu_op),
    .y     (alu_y),
    .zero  (alu_zero),
    .over  (alu_over)
  );

  // PC: exception beats stall beats branch beats sequential
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pc <= RESET_PC;
    else if (except) pc <= EXC_VECTOR;
    else if (!stall) pc <= br ? pc_branch : pc4_if;
  end

  // IF/ID: cleared on exception, held on stall, kept on taken branch (delay slot)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || except) begin
      ifid_pc4  <= 32'h0;
      ifid_inst <= 32'h0;
    end else if (!stall) begin
      ifid_pc4  <= pc4_if;
      ifid_inst <= inst_if;
    end
  end

  // ID/EX: bubble on stall, and kill the successor of an overflowing op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  idex <= '0;
    else if (stall || alu_over) idex <= '0;
    else idex <= '{ex: ex_id, m: m_id, wb: wb_id, rd1: rd1_id, rd2: rd2_id,
                   imm: imm_id, shamt: shamt_id, rs: rs_id, rt: rt_id, rd: rd_id};
  end

  // EX/MEM: an overflowing op loses its write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res               <= 32'h0;
      write_data_ex     <= 32'h0;
      write_register_ex <= 5'd0;
      m_mem             <= 3'b000;
      wb_mem            <= 2'b00;
      zero              <= 1'b0;
      over              <= 1'b0;
    end else begin
      res               <= alu_y;
      write_data_ex     <= fwd_b;
      write_register_ex <= idex.ex.reg_dst ? idex.rd : idex.rt;
      m_mem             <= idex.m;
      wb_mem            <= alu_over ? 2'b00 : idex.wb;
      zero              <= alu_zero;
      over              <= alu_over;
    end
  end

endmodule

// File: tb/tb_mips_front_pipe.sv
// Directed bench for mips_front_pipe. A tiny MEM/WB model feeds EX/MEM
// back into the WB ports one cycle later; loads return LOAD_VAL.
module tb_mips_front_pipe;

  localparam logic [31:0] LOAD_VAL = 32'h0000_0123;

  logic        clk, rst, except;
  logic        wb_reg_write;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data;
  logic [31:0] res, write_data_ex, pc_if, inst_id;
  logic [4:0]  write_register_ex;
  logic [2:0]  m_mem;
  logic [1:0]  wb_mem;
  logic        zero, over;

  int n_vec = 0;
  int n_err = 0;

  mips_front_pipe dut (
    .clk               (clk),
    .rst               (rst),
    .except            (except),
    .wb_reg_write      (wb_reg_write),
    .wb_write_register (wb_write_register),
    .wb_write_data     (wb_write_data),
    .res               (res),
    .write_data_ex     (write_data_ex),
    .write_register_ex (write_register_ex),
    .m_mem             (m_mem),
    .wb_mem            (wb_mem),
    .zero              (zero),
    .over              (over),
    .pc_if             (pc_if),
    .inst_id           (inst_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; WB ports take the EX/MEM contents that were present before the edge
  task automatic tick();
    logic        t_rw;
    logic [4:0]  t_wr;
    logic [31:0] t_wd;
    t_rw = wb_mem[1];
    t_wr = write_register_ex;
    t_wd = wb_mem[0] ? LOAD_VAL : res;
    @(posedge clk);
    #1;
    wb_reg_write      = t_rw;
    wb_write_register = t_wr;
    wb_write_data     = t_wd;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    except = 1'b0;
    wb_reg_write = 1'b0;
    wb_write_register = 5'd0;
    wb_write_data = 32'h0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) dut.rom[i] = 32'h0;
  endtask

  task automatic load_prog_a();
    dut.rom[0] = 32'h2001_0005;  // addi r1,r0,5
    dut.rom[1] = 32'h2002_0007;  // addi r2,r0,7
    dut.rom[2] = 32'h0022_1820;  // add  r3,r1,r2
  endtask

  task automatic load_branch(input logic [31:0] br_inst);
    dut.rom[4] = br_inst;        // at 0x10
    dut.rom[5] = 32'h2005_0009;  // addi r5,r0,9     delay slot
    dut.rom[6] = 32'h2006_0066;  // addi r6,r0,0x66  skipped when taken
    dut.rom[7] = 32'h2007_0077;  // addi r7,r0,0x77  target 0x1C
  endtask

  initial begin
    // ---- program A: forwarding from EX/MEM and WB ----
    hold_reset();
    load_prog_a();
    rst = 1'b1;
    chk("a_pc0", pc_if, 32'h0);
    ticks(3);
    chk("a_res_r1", res, 32'd5);
    chk("a_dst_r1", 32'(write_register_ex), 32'd1);
    tick();
    chk("a_res_r2", res, 32'd7);
    tick();
    chk("a_add_res", res, 32'd12);
    chk("a_add_dst", 32'(write_register_ex), 32'd3);
    chk("a_add_wb", 32'(wb_mem), 32'h2);
    chk("a_add_wdata", write_data_ex, 32'd7);
    chk("a_pc_nostall", pc_if, 32'h14);

    // ---- asynchronous reset mid-run ----
    rst = 1'b0;
    wb_reg_write = 1'b0;
    wb_write_register = 5'd0;
    wb_write_data = 32'h0;
    #1;
    chk("rst_pc", pc_if, 32'h0);
    chk("rst_inst", inst_id, 32'h0);
    chk("rst_res", res, 32'h0);
    chk("rst_wdata", write_data_ex, 32'h0);
    chk("rst_dst", 32'(write_register_ex), 32'h0);
    chk("rst_m", 32'(m_mem), 32'h0);
    chk("rst_wb", 32'(wb_mem), 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);
    chk("rst_over", 32'(over), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("seq_pc0", pc_if, 32'h0);
    tick();
    chk("seq_pc4", pc_if, 32'h4);
    tick();
    chk("seq_pc8", pc_if, 32'h8);

    // ---- program B: load-use stall ----
    hold_reset();
    dut.rom[0] = 32'h8C01_0000;  // lw  r1,0(r0)
    dut.rom[1] = 32'h0021_1020;  // add r2,r1,r1
    rst = 1'b1;
    ticks(2);
    chk("lu_pc8", pc_if, 32'h8);
    tick();
    chk("lu_pc_held", pc_if, 32'h8);
    chk("lu_inst_held", inst_id, 32'h0021_1020);
    chk("lu_lw_wb", 32'(wb_mem), 32'h3);
    chk("lu_lw_m", 32'(m_mem), 32'h2);
    tick();
    chk("lu_pc12", pc_if, 32'hC);
    chk("lu_bubble_wb", 32'(wb_mem), 32'h0);
    tick();
    chk("lu_add_res", res, 32'h246);
    chk("lu_add_dst", 32'(write_register_ex), 32'd2);
    chk("lu_add_wb", 32'(wb_mem), 32'h2);

    // ---- program C: taken beq with delay slot ----
    hold_reset();
    load_branch(32'h1000_0002);  // beq r0,r0,+2
    rst = 1'b1;
    ticks(5);
    chk("beq_pc14", pc_if, 32'h14);
    tick();
    chk("beq_target", pc_if, 32'h1C);
    tick();
    chk("beq_m", 32'(m_mem), 32'h4);
    tick();
    chk("beq_slot_res", res, 32'd9);
    chk("beq_slot_dst", 32'(write_register_ex), 32'd5);
    tick();
    chk("beq_tgt_res", res, 32'h77);
    chk("beq_tgt_dst", 32'(write_register_ex), 32'd7);

    // ---- program D: bne with equal operands falls through ----
    hold_reset();
    load_branch(32'h1400_0002);  // bne r0,r0,+2
    rst = 1'b1;
    ticks(6);
    chk("bne_pc18", pc_if, 32'h18);
    ticks(2);
    chk("bne_slot_res", res, 32'd9);
    tick();
    chk("bne_seq_res", res, 32'h66);
    chk("bne_seq_dst", 32'(write_register_ex), 32'd6);

    // ---- program E: signed overflow on addi, none on addiu ----
    hold_reset();
    dut.rom[0] = 32'h3C01_7FFF;  // lui   r1,0x7fff
    dut.rom[1] = 32'h3421_FFFF;  // ori   r1,r1,0xffff
    dut.rom[2] = 32'h2022_0001;  // addi  r2,r1,1   overflows
    dut.rom[3] = 32'h2004_0044;  // addi  r4,r0,0x44 flushed
    dut.rom[4] = 32'h2423_0001;  // addiu r3,r1,1
    rst = 1'b1;
    ticks(3);
    chk("ov_lui", res, 32'h7FFF_0000);
    tick();
    chk("ov_ori", res, 32'h7FFF_FFFF);
    tick();
    chk("ov_addi_over", 32'(over), 32'h1);
    chk("ov_addi_wb", 32'(wb_mem), 32'h0);
    chk("ov_addi_res", res, 32'h8000_0000);
    tick();
    chk("ov_one_cycle", 32'(over), 32'h0);
    chk("ov_flush_wb", 32'(wb_mem), 32'h0);
    chk("ov_flush_dst", 32'(write_register_ex), 32'h0);
    tick();
    chk("addiu_over", 32'(over), 32'h0);
    chk("addiu_wb", 32'(wb_mem), 32'h2);
    chk("addiu_res", res, 32'h8000_0000);
    chk("addiu_dst", 32'(write_register_ex), 32'd3);

    // ---- exception redirect ----
    hold_reset();
    load_prog_a();
    dut.rom[96] = 32'h2008_0001;  // at 0x8000_0180
    rst = 1'b1;
    ticks(2);
    chk("exc_pre_inst", inst_id, 32'h2002_0007);
    except = 1'b1;
    tick();
    except = 1'b0;
    chk("exc_pc", pc_if, 32'h8000_0180);
    chk("exc_inst_nop", inst_id, 32'h0);
    tick();
    chk("exc_pc_next", pc_if, 32'h8000_0184);
    chk("exc_vec_inst", inst_id, 32'h2008_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_front_pipe.md
Name: mips_front_pipe

Overview:
- Combined IF, ID and EX stages of a 5-stage MIPS R2000 integer pipeline. Contains: PC, instruction ROM, IF/ID register, register file, control, branch/jump resolution, hazard unit, ID/EX register, ALU with forwarding, and EX/MEM register.
- Drives the external MEM stage.
- Receives write-back from the external WB stage.
- Branches and jumps resolve in ID with one architectural delay slot.

Parameters:
- IMEM_DEPTH, 256, instruction ROM depth in words, indexed by pc[log2(IMEM_DEPTH)+1:2].
- IMEM_FILE, "program.hex", $readmemh init file.
- RESET_PC, 32'h0000_0000, PC after reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on except.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- except  in  1  external exception request
- wb_reg_write  in  1  WB-stage register write enable
- wb_write_register  in  5  WB destination register
- wb_write_data  in  32  WB write data
- res  out  32  EX/MEM ALU result / memory address
- write_data_ex  out  32  EX/MEM store data (forwarded rt)
- write_register_ex  out  5  EX/MEM destination register
- m_mem  out  3  {branch, mem_read, mem_write}
- wb_mem  out  2  {reg_write, mem_to_reg}
- zero  out  1  EX/MEM registered ALU result==0
- over  out  1  EX/MEM registered signed overflow
- pc_if  out  32  current PC (debug)
- inst_id  out  32  IF/ID instruction (debug)

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_PC.
  - IF/ID, ID/EX and EX/MEM all cleared; inst 0 = NOP.
  - All outputs 0.
  - Register file is not reset, except r0, which is hardwired to 0.
- PC next-state priority:
  1. except → EXC_VECTOR.
  2. hold (stall) → unchanged.
  3. br → pc_branch.
  4. otherwise pc+4.
- IF/ID register:
  - Loads {pc+4, ROM[pc]} each cycle unless held.
  - Cleared on except.
  - Not flushed on a taken branch, so the delay slot executes.
- Register file, 32x32:
  - Written on rising clk when wb_reg_write and wb_write_register != 0.
  - Two read ports.
  - Same-cycle write-to-read bypass.
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl.
  - I-type: addi, addiu, andi, ori, xori, slti, lui, lw, sw, beq, bne.
  - Jump: j.
  - Any other opcode decodes as NOP, with all control bits 0.
- Control packing:
  - ex = {reg_dst, alu_src, alu_op[3:0]}.
  - alu_op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, LUI=10, ADDU=11, SUBU=12.
- Immediates:
  - Sign-extended for arithmetic, slti, lw, sw and branches.
  - Zero-extended for andi, ori and xori.
- Branch/jump targets:
  - beq/bne: pc_branch = (pc+4) + (sext(imm)<<2); br=1 when the condition holds.
  - j: pc_branch = {pc+4[31:28], target, 2'b00}; br=1.
- Branch compare operands:
  - Register-file data, with EX/MEM res forwarded when the EX/MEM destination matches and reg_write && !mem_read.
- Hazard unit (stall = hold PC and IF/ID, insert bubble into ID/EX):
  - Load-use: ID/EX mem_read and its destination equals ID rs or rt (nonzero).
  - Branch dependency: ID instruction is beq/bne and ID/EX reg_write with destination equal to rs or rt; or EX/MEM mem_read with destination equal to rs or rt.
- EX forwarding, per operand:
  - Priority 1: EX/MEM (reg_write, dest!=0, !mem_read) → res.
  - Priority 2: WB (wb_reg_write, dest!=0) → wb_write_data.
  - Otherwise: ID/EX register data.
  - write_data_ex is the forwarded rt.
- Shifts use shamt. Destination is rd when reg_dst=1, else rt.
- Overflow:
  - add, sub and addi set over on signed overflow.
  - On overflow the EX/MEM wb bits are forced to 0 (no write-back).
  - The overflowing instruction's successor in ID/EX is flushed.
  - over stays registered for one cycle.
- Latency: an instruction fetched at cycle n presents res at EX/MEM output after cycle n+3.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode and funct constants.
  - alu_op_t enum.
  - Packed types for the ex, m and wb control bundles.
  - EXC_VECTOR.
- One natural sub-module: mips_alu, a combinational 32-bit ALU with zero and overflow outputs.

Test Plan:
- Reset with rst=0 mid-run → pc_if=0 and all outputs 0 immediately. After release, PC sequences 0, 4, 8.
- ROM "addi r1,r0,5; addi r2,r0,7; add r3,r1,r2" → res=12 with write_register_ex=3. EX/MEM forwarding is exercised; no stall.
- "lw r1,0(r0); add r2,r1,r1" → exactly one bubble: wb_mem=0 for one cycle and pc_if held one cycle.
- "beq r0,r0,+2" at PC 0x10 → delay slot 0x14 executes, then pc_if=0x1C. A bne with equal operands → sequential fetch.
- "lui r1,0x7fff; ori r1,r1,0xffff; addi r2,r1,1" → over=1 and wb_mem=00 for the addi. addiu in the same sequence → no overflow.
- except=1 for one cycle → next pc_if=0x8000_0180 and inst_id is NOP.
